// File: rtl/vga_pkg.sv
// Shared VGA definitions: capture FSM states and 640x480 timing constants.
package vga_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_FRAME,
      CAPTURE,
      DONE
   } capture_state_t;

   // 640x480 @ 60 Hz timing, shared with the timing generator.
   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] V_ACTIVE = 10'd480;
   localparam int unsigned H_FRONT = 16;
   localparam int unsigned H_SYNC  = 96;
   localparam int unsigned H_BACK  = 48;
   localparam int unsigned V_FRONT = 10;
   localparam int unsigned V_SYNC  = 2;
   localparam int unsigned V_BACK  = 33;

endpackage

// File: rtl/vga_frame_capture_if.sv
// Video input and frame-buffer write bundle seen by the frame capture block.
interface vga_frame_capture_if;

   logic        hs;
   logic        vs;
   logic        blank;
   logic [7:0]  r;
   logic [7:0]  g;
   logic [7:0]  b;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   // Video source side: drives pixels, observes frame-buffer writes.
   modport master (
      output hs, vs, blank, r, g, b,
      input  wr_en, wr_addr, wr_data
   );

   // Capture side: consumes pixels, produces frame-buffer writes.
   modport slave (
      input  hs, vs, blank, r, g, b,
      output wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/vga_frame_capture_sync.sv
// Single-bit input register with rising/falling edge pulses on the registered copy.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic q_d;

   // Register the input once, then keep one more stage for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q   <= 1'b0;
         q_d <= 1'b0;
      end else begin
         q   <= d;
         q_d <= q;
      end
   end

   // Edge pulses are valid for the cycle in which q holds the new level.
   always_comb begin
      rise = q & ~q_d;
      fall = ~q & q_d;
   end

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one VGA frame into a word-addressed frame buffer after a start pulse.
module vga_frame_capture
   import vga_pkg::*;
#(
   parameter logic [9:0]  HACTIVE = H_ACTIVE,
   parameter logic [9:0]  VACTIVE = V_ACTIVE,
   parameter logic        HS_POL  = 1'b0,
   parameter logic        VS_POL  = 1'b0,
   parameter logic [31:0] BASE    = 32'd0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   vga_frame_capture_if.slave  vif,
   output logic                busy,
   output logic                frame_done,
   output logic                err_h,
   output logic                err_v
);

   localparam logic [10:0] HACT11 = {1'b0, HACTIVE};
   localparam logic [10:0] VACT11 = {1'b0, VACTIVE};

   capture_state_t state, state_next;

   logic        hs_q, hs_rise, hs_fall;
   logic        vs_q, vs_rise, vs_fall;
   logic        blank_q, blank_rise, blank_fall;
   logic [23:0] rgb_q;
   logic [10:0] x, y;
   logic [31:0] line_base, addr;
   logic        cap_en, arm_clear, pix_ok, hs_bad;

   // Syncs are normalised to active-high before registering.
   sync_edge_detect u_hs (
      .clk(clk), .rst(rst), .d(vif.hs == HS_POL),
      .q(hs_q), .rise(hs_rise), .fall(hs_fall)
   );
   sync_edge_detect u_vs (
      .clk(clk), .rst(rst), .d(vif.vs == VS_POL),
      .q(vs_q), .rise(vs_rise), .fall(vs_fall)
   );
   sync_edge_detect u_blank (
      .clk(clk), .rst(rst), .d(vif.blank),
      .q(blank_q), .rise(blank_rise), .fall(blank_fall)
   );

   // Colour input register, aligned with the registered sync/blank copies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rgb_q <= '0;
      else     rgb_q <= {vif.r, vif.g, vif.b};
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (start)   state_next = ARM;
         ARM:        if (vs_rise) state_next = WAIT_FRAME;
         WAIT_FRAME: if (vs_fall) state_next = CAPTURE;
         CAPTURE:    if (vs_rise) state_next = DONE;
         DONE:                    state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   // FSM output decode.
   always_comb begin
      busy       = 1'b0;
      frame_done = 1'b0;
      cap_en     = 1'b0;
      arm_clear  = 1'b0;
      case (state)
         IDLE:       arm_clear  = start;
         ARM:        busy       = 1'b1;
         WAIT_FRAME: busy       = 1'b1;
         CAPTURE: begin
            busy   = 1'b1;
            cap_en = 1'b1;
         end
         DONE:       frame_done = 1'b1;
         default:    ;
      endcase
   end

   // Pixel qualification; an hs edge with blank held high means the previous
   // sample was active video with hs asserted, so it is flagged as well.
   always_comb begin
      pix_ok = cap_en && blank_q && !vs_q && (x < HACT11) && (y < VACT11);
      hs_bad = blank_q && (hs_q || hs_rise || (hs_fall && !blank_rise));
   end

   // Write port, coordinate/address counters and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vif.wr_en   <= 1'b0;
         vif.wr_addr <= '0;
         vif.wr_data <= '0;
         x           <= '0;
         y           <= '0;
         line_base   <= '0;
         addr        <= '0;
         err_h       <= 1'b0;
         err_v       <= 1'b0;
      end else begin
         vif.wr_en <= pix_ok;
         if (pix_ok) begin
            vif.wr_addr <= addr;
            vif.wr_data <= {8'h00, rgb_q};
            addr        <= addr + 32'd1;
         end
         if (arm_clear) begin
            x         <= '0;
            y         <= '0;
            line_base <= BASE;
            addr      <= BASE;
            err_h     <= 1'b0;
            err_v     <= 1'b0;
         end else if (cap_en) begin
            if (blank_q) begin
               if (x != '1) x <= x + 11'd1;
               if (hs_bad)  err_h <= 1'b1;
            end
            // blank_q is low on a falling edge, so no pixel update collides here.
            if (blank_fall) begin
               err_h     <= err_h | (x != HACT11);
               x         <= '0;
               if (y != '1) y <= y + 11'd1;
               line_base <= line_base + 32'(HACTIVE);
               addr      <= line_base + 32'(HACTIVE);
            end
            if (vs_rise) err_v <= err_v | (y != VACT11);
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture with a frame-level reference model.
module tb_vga_frame_capture;

   localparam logic [9:0]  HACT  = 10'd8;
   localparam logic [9:0]  VACT  = 10'd4;
   localparam logic        HSP   = 1'b0;
   localparam logic        VSP   = 1'b0;
   localparam logic [31:0] BASEA = 32'h100;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic eh;
      logic ev;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic busy, frame_done, err_h, err_v;

   vga_frame_capture_if vif();

   vga_frame_capture #(
      .HACTIVE(HACT), .VACTIVE(VACT), .HS_POL(HSP), .VS_POL(VSP), .BASE(BASEA)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .vif(vif),
      .busy(busy), .frame_done(frame_done), .err_h(err_h), .err_v(err_v)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   wr_t  exp_q[$];
   res_t res_q[$];

   // Reference model state: armed waiting for a frame, capturing, per-frame tallies.
   bit m_armed = 1'b0;
   bit m_cap   = 1'b0;
   int m_lines = 0;
   bit m_eh    = 1'b0;
   bit start_on_done = 1'b0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Monitor: pops expected writes and frame results when the DUT presents them.
   initial begin
      wr_t  e;
      res_t r;
      forever begin
         @(negedge clk);
         if (vif.wr_en === 1'b1) begin
            chk("wr_en_in_capture", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                        vif.wr_addr, vif.wr_data);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", vif.wr_addr, e.addr);
               chk("wr_data", vif.wr_data, e.data);
            end
         end
         if (frame_done === 1'b1) begin
            if (res_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_frame_done: got pulse expected none");
            end else begin
               r = res_q.pop_front();
               chk("err_h", 32'(err_h), 32'(r.eh));
               chk("err_v", 32'(err_v), 32'(r.ev));
            end
         end
      end
   end

   task automatic tick(input bit hs_a, input bit vs_a, input bit bl, input logic [23:0] rgb);
      vif.hs    = hs_a ? HSP : ~HSP;
      vif.vs    = vs_a ? VSP : ~VSP;
      vif.blank = bl;
      {vif.r, vif.g, vif.b} = rgb;
      @(negedge clk);
      if (start_on_done && frame_done) begin
         start = 1'b1;
         start_on_done = 1'b0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 1'b0, 24'h0);
   endtask

   // Start request; only an idle capture block accepts it.
   task automatic do_start();
      start = 1'b1;
      if (!m_armed && !m_cap) m_armed = 1'b1;
   endtask

   task automatic send_vsync(input bit start_in_done);
      if (m_cap) begin
         res_q.push_back('{m_eh, (m_lines != int'(VACT))});
         m_cap = 1'b0;
      end
      start_on_done = start_in_done;
      repeat (3) tick(1'b0, 1'b1, 1'b0, 24'h0);
      start_on_done = 1'b0;
      if (m_armed) begin
         m_cap   = 1'b1;
         m_armed = 1'b0;
         m_lines = 0;
         m_eh    = 1'b0;
      end
      idle(2);
   endtask

   task automatic reset_mid();
      rst = 1'b1;
      #1;
      chk("rst_wr_en", 32'(vif.wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      m_cap   = 1'b0;
      m_armed = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_frame(input int nlines, input int odd_line, input int odd_px,
                             input int start_line, input int rst_line);
      send_vsync(1'b0);
      for (int l = 0; l < nlines; l++) begin
         int px;
         px = (l == odd_line) ? odd_px : int'(HACT);
         if (l == start_line) do_start();
         idle(2);
         for (int i = 0; i < px; i++) begin
            logic [23:0] c;
            c = 24'($urandom);
            if (l == rst_line && i == 3) begin
               reset_mid();
               return;
            end
            if (m_cap && m_lines < int'(VACT) && i < int'(HACT))
               exp_q.push_back('{BASEA + 32'(m_lines) * 32'(HACT) + 32'(i), {8'h00, c}});
            tick(1'b0, 1'b0, 1'b1, c);
         end
         if (m_cap && px > 0) begin
            if (px != int'(HACT)) m_eh = 1'b1;
            m_lines++;
         end
         idle(2);
         repeat (2) tick(1'b1, 1'b0, 1'b0, 24'h0);
      end
      idle(2);
   endtask

   initial begin
      vif.hs = ~HSP;
      vif.vs = ~VSP;
      vif.blank = 1'b0;
      {vif.r, vif.g, vif.b} = 24'h0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_wr_en", 32'(vif.wr_en), 32'd0);
      chk("reset_wr_addr", vif.wr_addr, 32'd0);
      chk("reset_wr_data", vif.wr_data, 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_frame_done", 32'(frame_done), 32'd0);
      chk("reset_err_h", 32'(err_h), 32'd0);
      chk("reset_err_v", 32'(err_v), 32'd0);
      rst = 1'b0;
      idle(3);

      // Clean frame.
      do_start();
      idle(3);
      chk("busy_armed", 32'(busy), 32'd1);
      send_frame(4, -1, 0, -1, -1);
      send_vsync(1'b0);
      chk("idle_after_done", 32'(busy), 32'd0);

      // Start mid-frame: that frame is skipped, the next one is captured.
      send_frame(4, -1, 0, 2, -1);
      send_frame(4, -1, 0, -1, -1);
      send_vsync(1'b0);

      // Line with one pixel too many.
      do_start();
      idle(3);
      send_frame(4, 2, 9, -1, -1);
      send_vsync(1'b0);

      // Short frame.
      do_start();
      idle(3);
      send_frame(3, -1, 0, -1, -1);
      send_vsync(1'b0);

      // Reset in the middle of line 1, then a full capture.
      do_start();
      idle(3);
      send_frame(4, -1, 0, -1, 1);
      idle(2);
      chk("busy_after_rst", 32'(busy), 32'd0);
      do_start();
      idle(3);
      send_frame(4, -1, 0, -1, -1);
      send_vsync(1'b0);

      // Start during CAPTURE and during DONE are ignored; a later start arms.
      do_start();
      idle(3);
      send_frame(4, -1, 0, 1, -1);
      send_vsync(1'b1);
      chk("no_rearm", 32'(busy), 32'd0);
      do_start();
      idle(1);
      chk("rearm", 32'(busy), 32'd1);
      send_frame(4, 1, 0, -1, -1);
      send_vsync(1'b0);

      // Randomised frames: line counts, short/long/blank-only lines.
      repeat (8) begin
         int nl, ol, opx, sel;
         nl  = int'($urandom_range(3, 5));
         ol  = int'($urandom_range(0, 5)) - 1;
         sel = int'($urandom_range(0, 3));
         opx = (sel == 0) ? 0 : (sel == 1) ? 7 : (sel == 2) ? 9 : 8;
         do_start();
         idle(int'($urandom_range(1, 4)));
         send_frame(nl, ol, opx, -1, -1);
         send_vsync(1'b0);
      end

      idle(5);
      chk("pending_writes", 32'(exp_q.size()), 32'd0);
      chk("pending_frames", 32'(res_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
